// File: rtl/rr_decode_arbiter16.sv
// Round-robin arbiter sharing one 16-way decoded select among 16 requesters.
// Holds a 4-bit grant address plus its gated one-hot decode; bounded hold time.
module rr_decode_arbiter16 #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_oh,
  output logic             timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int HL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [N-1:0] ONE = N'(1);

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] hold_cnt;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             hold_hit;
  logic             owner_req;

  // Rotating search starting just after the last owner; i=N wraps to it.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last_idx + IDX_W'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(HL));
  assign owner_req = req[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grant_oh    <= '0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      last_idx    <= IDX_W'(N - 1);
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state       <= BUSY;
            grant_valid <= 1'b1;
            grant_idx   <= winner;
            grant_oh    <= ONE << winner;
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          if (done || !owner_req || hold_hit) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_oh    <= '0;
            last_idx    <= grant_idx;
            // done takes priority, so a coincident limit is not a timeout
            timeout     <= !done && owner_req && hold_hit;
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter16.sv
// Directed bench for rr_decode_arbiter16.
// Expected outputs are queued as stimulus is driven, popped on output.
module tb_rr_decode_arbiter16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_oh;
  logic        timeout;

  typedef struct {
    logic       v;
    logic [3:0] idx;
    logic       to;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_decode_arbiter16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .grant_oh   (grant_oh),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic push(input logic v, input logic [3:0] idx,
                      input logic to, input string tag);
    exp_t e;
    e.v   = v;
    e.idx = idx;
    e.to  = to;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [15:0] oh;
    n_cmp++;
    assert (q.size() != 0) else begin
      n_bad++;
      $error("FAIL scoreboard: got empty queue want entry");
    end
    if (q.size() != 0) begin
      e  = q.pop_front();
      oh = e.v ? (16'h0001 << e.idx) : 16'h0000;
      n_cmp++;
      assert (grant_valid === e.v) else begin
        n_bad++;
        $error("FAIL %s valid: got %0b want %0b", e.tag, grant_valid, e.v);
      end
      n_cmp++;
      assert (grant_idx === e.idx) else begin
        n_bad++;
        $error("FAIL %s idx: got %0d want %0d", e.tag, grant_idx, e.idx);
      end
      n_cmp++;
      assert (grant_oh === oh) else begin
        n_bad++;
        $error("FAIL %s oh: got %h want %h", e.tag, grant_oh, oh);
      end
      n_cmp++;
      assert (timeout === e.to) else begin
        n_bad++;
        $error("FAIL %s timeout: got %0b want %0b", e.tag, timeout, e.to);
      end
    end
  endtask

  // Drive one cycle of inputs, expect the registered result after the edge.
  task automatic cyc(input logic [15:0] r, input logic d, input logic v,
                     input logic [3:0] idx, input logic to,
                     input string tag);
    req  = r;
    done = d;
    push(v, idx, to, tag);
    @(posedge clk);
    #1;
    chk();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    push(1'b0, 4'd0, 1'b0, "reset");
    chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int seq[5] = '{0, 8, 15, 0, 8};

  initial begin
    @(posedge clk);
    #1;
    apply_reset();

    // idle with no requests, done in idle ignored
    cyc(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "idle0");
    cyc(16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, "idle_done");
    cyc(16'h0001, 1'b1, 1'b1, 4'd0, 1'b0, "grant0");
    cyc(16'h0001, 1'b1, 1'b0, 4'd0, 1'b0, "done0");

    // fairness across 0, 8, 15 with wrap
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(16'h8101, 1'b0, 1'b1, 4'(seq[k]), 1'b0, "fair_g");
      cyc(16'h8101, 1'b1, 1'b0, 4'(seq[k]), 1'b0, "fair_r");
    end

    // hold limit: 8 cycles each, timeout pulse on release
    apply_reset();
    for (int k = 0; k < 8; k++)
      cyc(16'h0006, 1'b0, 1'b1, 4'd1, 1'b0, "hold1");
    cyc(16'h0006, 1'b0, 1'b0, 4'd1, 1'b1, "to1");
    for (int k = 0; k < 8; k++)
      cyc(16'h0006, 1'b0, 1'b1, 4'd2, 1'b0, "hold2");
    cyc(16'h0006, 1'b0, 1'b0, 4'd2, 1'b1, "to2");
    cyc(16'h0006, 1'b0, 1'b1, 4'd1, 1'b0, "regrant1");

    // done on the final allowed cycle wins over timeout
    for (int k = 0; k < 7; k++)
      cyc(16'h0006, 1'b0, 1'b1, 4'd1, 1'b0, "hold1b");
    cyc(16'h0006, 1'b1, 1'b0, 4'd1, 1'b0, "done_vs_to");

    // owner drops request
    cyc(16'h0006, 1'b0, 1'b1, 4'd2, 1'b0, "grant2");
    cyc(16'h0002, 1'b0, 1'b0, 4'd2, 1'b0, "drop2");
    cyc(16'h0000, 1'b0, 1'b0, 4'd2, 1'b0, "idle_keep");

    // single requester at 15 is re-granted
    apply_reset();
    cyc(16'h8000, 1'b0, 1'b1, 4'd15, 1'b0, "g15");
    cyc(16'h8000, 1'b1, 1'b0, 4'd15, 1'b0, "r15");
    cyc(16'h8000, 1'b0, 1'b1, 4'd15, 1'b0, "g15_again");
    cyc(16'h8000, 1'b1, 1'b0, 4'd15, 1'b0, "r15_again");
    cyc(16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, "idle15");

    // asynchronous reset mid-grant
    apply_reset();
    cyc(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0, "g5");
    rst_n = 1'b0;
    #1;
    push(1'b0, 4'd0, 1'b0, "async_rst");
    chk();
    req = 16'h0030;
    #1;
    rst_n = 1'b1;
    push(1'b1, 4'd4, 1'b0, "post_rst4");
    @(posedge clk);
    #1;
    chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
